instr_line_buffer: RTL and testbench

//  Four-slot, 16B-line instruction buffer between the I-cache and fetch_2 (rotate/align stage).

---
 rtl/instr_line_buffer_pkg.sv | 25 ++
 rtl/ilb_slot_valid.sv | 40 ++++
 rtl/instr_line_buffer.sv | 143 ++++++++++++++
 tb/tb_instr_line_buffer.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_line_buffer_pkg.sv
// Shared definitions for the instruction line buffer.
// Holds the fill FSM state encoding, line and slot geometry, and a helper
// that maps a byte offset within the 64B window to its slot index.
package instr_line_buffer_pkg;

  localparam int LINE_BYTES = 16;
  localparam int LINE_BITS  = LINE_BYTES * 8;
  localparam int NUM_SLOTS  = 4;
  localparam int SLOT_IDX_W = 2;

  typedef logic [SLOT_IDX_W-1:0] slot_idx_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_DROP
  } ilb_state_e;

  // Slot index of a byte offset within the 64B window (offset bits [5:4]).
  function automatic slot_idx_t slot_of(input logic [5:0] byte_off);
    return slot_idx_t'(byte_off >> 4);
  endfunction

endpackage

// File: rtl/ilb_slot_valid.sv
// Per-slot valid vector for the instruction line buffer.
// Ports:
//   clk, reset        clock and synchronous active-high reset
//   flush             clear every slot (wins over set/clear)
//   set_en, set_idx   mark a slot valid after a fill
//   clr_en, clr_idx   mark a slot free once fetch_2 has left it
//   valid             registered valid bits, one per slot
module ilb_slot_valid
  import instr_line_buffer_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 set_en,
  input  slot_idx_t            set_idx,
  input  logic                 clr_en,
  input  slot_idx_t            clr_idx,
  output logic [NUM_SLOTS-1:0] valid
);

  logic [NUM_SLOTS-1:0] valid_d;
  logic [NUM_SLOTS-1:0] valid_q;

  // A fill only ever targets an invalid slot, so set and clear never
  // collide on the same index; both are applied.
  always_comb begin
    valid_d = valid_q;
    if (clr_en) valid_d[clr_idx] = 1'b0;
    if (set_en) valid_d[set_idx] = 1'b1;
    if (flush)  valid_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) valid_q <= '0;
    else       valid_q <= valid_d;
  end

  assign valid = valid_q;

endmodule

// File: rtl/instr_line_buffer.sv
// Four-slot, 16B-line instruction buffer between the I-cache and fetch_2.
// Requests sequential lines from the I-cache into free slots (slot index is
// line address bits [5:4]), frees a slot when fetch_2's BIP leaves it and
// drops everything on a flush.
// Ports:
//   clk, reset                  clock and synchronous active-high reset
//   flush, flush_addr           resteer: new fetch target, all lines dropped
//   consume, old_BIP, new_BIP   fetch_2 BIP advance, used to free slots
//   ic_req_valid/addr/ready     line request handshake to the I-cache
//   ic_resp_valid/data          in-order line fill from the I-cache
//   line_00..line_11 (+_valid)  registered slot contents for fetch_2
module instr_line_buffer
  import instr_line_buffer_pkg::*;
#(
  parameter int                    ADDR_WIDTH   = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic [ADDR_WIDTH-1:0] flush_addr,
  input  logic                  consume,
  input  logic [5:0]            old_BIP,
  input  logic [5:0]            new_BIP,
  output logic                  ic_req_valid,
  output logic [ADDR_WIDTH-1:0] ic_req_addr,
  input  logic                  ic_req_ready,
  input  logic                  ic_resp_valid,
  input  logic [LINE_BITS-1:0]  ic_resp_data,
  output logic [LINE_BITS-1:0]  line_00,
  output logic [LINE_BITS-1:0]  line_01,
  output logic [LINE_BITS-1:0]  line_10,
  output logic [LINE_BITS-1:0]  line_11,
  output logic                  line_00_valid,
  output logic                  line_01_valid,
  output logic                  line_10_valid,
  output logic                  line_11_valid
);

  localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ~ADDR_WIDTH'(LINE_BYTES - 1);
  localparam logic [ADDR_WIDTH-1:0] LINE_INC  = ADDR_WIDTH'(LINE_BYTES);

  ilb_state_e            state_d, state_q;
  logic [ADDR_WIDTH-1:0] fetch_addr_d, fetch_addr_q;
  logic                  req_valid_d, req_valid_q;
  logic [LINE_BITS-1:0]  line_d [NUM_SLOTS];
  logic [LINE_BITS-1:0]  line_q [NUM_SLOTS];

  logic [NUM_SLOTS-1:0]  slot_valid;
  slot_idx_t             fill_idx;
  slot_idx_t             free_idx;
  logic                  fill_en;
  logic                  free_en;

  // Fill lands in the slot of the current fetch address; a flush in the same
  // cycle discards the response. Free happens when the BIP advance crosses a
  // 16B boundary (at most one, since instructions are at most 15B).
  always_comb begin
    fill_idx = slot_of(fetch_addr_q[5:0]);
    free_idx = slot_of(old_BIP);
    fill_en  = !flush && (state_q == ST_WAIT) && ic_resp_valid;
    free_en  = !flush && consume && (slot_of(new_BIP) != free_idx);
  end

  ilb_slot_valid u_slot_valid (
    .clk     (clk),
    .reset   (reset),
    .flush   (flush),
    .set_en  (fill_en),
    .set_idx (fill_idx),
    .clr_en  (free_en),
    .clr_idx (free_idx),
    .valid   (slot_valid)
  );

  // Fill FSM: at most one outstanding request. On flush the request is
  // withdrawn, or the in-flight response is routed to DROP so it never
  // lands in the new window.
  always_comb begin
    state_d      = state_q;
    fetch_addr_d = fetch_addr_q;
    unique case (state_q)
      ST_IDLE: if (!slot_valid[fill_idx]) state_d = ST_REQ;
      ST_REQ:  if (ic_req_ready) state_d = ST_WAIT;
      ST_WAIT: begin
        if (ic_resp_valid) begin
          state_d      = ST_IDLE;
          fetch_addr_d = fetch_addr_q + LINE_INC;
        end
      end
      ST_DROP: if (ic_resp_valid) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (flush) begin
      fetch_addr_d = flush_addr & LINE_MASK;
      unique case (state_q)
        ST_REQ:  state_d = ic_req_ready ? ST_DROP : ST_IDLE;
        ST_WAIT: state_d = ic_resp_valid ? ST_IDLE : ST_DROP;
        // Still waiting on the stale response; if it shows up now it is
        // consumed here, otherwise DROP keeps waiting for it.
        ST_DROP: state_d = ic_resp_valid ? ST_IDLE : ST_DROP;
        default: state_d = ST_IDLE;
      endcase
    end

    req_valid_d = (state_d == ST_REQ);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      fetch_addr_q <= RESET_VECTOR & LINE_MASK;
      req_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      fetch_addr_q <= fetch_addr_d;
      req_valid_q  <= req_valid_d;
    end
  end

  // Line data is not reset; the valid bits qualify it.
  always_comb begin
    line_d = line_q;
    if (fill_en) line_d[fill_idx] = ic_resp_data;
  end

  always_ff @(posedge clk) begin
    line_q <= line_d;
  end

  assign ic_req_valid  = req_valid_q;
  assign ic_req_addr   = fetch_addr_q;
  assign line_00       = line_q[0];
  assign line_01       = line_q[1];
  assign line_10       = line_q[2];
  assign line_11       = line_q[3];
  assign line_00_valid = slot_valid[0];
  assign line_01_valid = slot_valid[1];
  assign line_10_valid = slot_valid[2];
  assign line_11_valid = slot_valid[3];

endmodule

// File: tb/tb_instr_line_buffer.sv
// Directed testbench for instr_line_buffer with an I-cache responder model.
// Expected request addresses are queued by the directed steps and popped
// when the DUT's request is accepted; every fill returns a per-address
// data pattern so the bench can tell which line landed in which slot.
module tb_instr_line_buffer;

  logic         clk = 1'b0;
  logic         reset;
  logic         flush;
  logic [31:0]  flush_addr;
  logic         consume;
  logic [5:0]   old_BIP;
  logic [5:0]   new_BIP;
  logic         ic_req_valid;
  logic [31:0]  ic_req_addr;
  logic         ic_req_ready;
  logic         ic_resp_valid = 1'b0;
  logic [127:0] ic_resp_data = '0;
  logic [127:0] line_00, line_01, line_10, line_11;
  logic         line_00_valid, line_01_valid, line_10_valid, line_11_valid;

  int           total_checks  = 0;
  int           passed_checks = 0;
  logic [31:0]  exp_req_q[$];

  logic         acc_pending = 1'b0;
  logic [31:0]  acc_addr    = '0;
  logic         rst_seen    = 1'b0;
  int           resp_cnt    = 0;
  logic [31:0]  pend_addr   = '0;

  wire  [3:0]   vld = {line_11_valid, line_10_valid, line_01_valid, line_00_valid};

  instr_line_buffer #(
    .ADDR_WIDTH   (32),
    .RESET_VECTOR (32'h0000_0100)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .flush         (flush),
    .flush_addr    (flush_addr),
    .consume       (consume),
    .old_BIP       (old_BIP),
    .new_BIP       (new_BIP),
    .ic_req_valid  (ic_req_valid),
    .ic_req_addr   (ic_req_addr),
    .ic_req_ready  (ic_req_ready),
    .ic_resp_valid (ic_resp_valid),
    .ic_resp_data  (ic_resp_data),
    .line_00       (line_00),
    .line_01       (line_01),
    .line_10       (line_10),
    .line_11       (line_11),
    .line_00_valid (line_00_valid),
    .line_01_valid (line_01_valid),
    .line_10_valid (line_10_valid),
    .line_11_valid (line_11_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] pattern(input logic [31:0] a);
    return {a, ~a, a ^ 32'hDEAD_BEEF, a + 32'h0123_4567};
  endfunction

  task automatic checkOutput(input string tag, input logic [127:0] observed,
                             input logic [127:0] expected);
    total_checks++;
    assert (observed === expected) passed_checks++;
    else $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
  endtask

  // Drive one cycle of consume/flush from a negedge; ready stays as set.
  task automatic applyStimulus(input logic c, input logic [5:0] o, input logic [5:0] n,
                               input logic f, input logic [31:0] fa, input logic rdy);
    consume      = c;
    old_BIP      = o;
    new_BIP      = n;
    flush        = f;
    flush_addr   = fa;
    ic_req_ready = rdy;
    @(negedge clk);
    consume = 1'b0;
    flush   = 1'b0;
  endtask

  task automatic waitVld(input logic [3:0] target, input int budget, input string tag);
    int n = 0;
    while (vld !== target && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput(tag, 128'(vld), 128'(target));
  endtask

  task automatic waitReq(input int budget, input string tag);
    int n = 0;
    while (ic_req_valid !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput(tag, 128'(ic_req_valid), 128'(1'b1));
  endtask

  // Record accepted requests and reset at the clock edge the DUT sees.
  always @(posedge clk) begin
    acc_pending <= (ic_req_valid === 1'b1) && (ic_req_ready === 1'b1) && (reset === 1'b0);
    acc_addr    <= ic_req_addr;
    rst_seen    <= reset;
  end

  // I-cache model: response sampled two edges after the accepting edge.
  // A reset kills any pending response, as the cache resets with the DUT.
  always @(negedge clk) begin
    ic_resp_valid = 1'b0;
    if (rst_seen === 1'b1) resp_cnt = 0;
    if (resp_cnt == 1) begin
      ic_resp_valid = 1'b1;
      ic_resp_data  = pattern(pend_addr);
    end
    if (resp_cnt > 0) resp_cnt--;
    if (acc_pending === 1'b1) begin
      if (exp_req_q.size() == 0) begin
        total_checks++;
        $error("[TB] FAIL unexpected_req observed=%h expected=none", acc_addr);
      end else begin
        checkOutput("req_addr", 128'(acc_addr), 128'(exp_req_q.pop_front()));
      end
      pend_addr = acc_addr;
      resp_cnt  = 1;
    end
  end

  initial begin
    reset        = 1'b1;
    flush        = 1'b0;
    flush_addr   = '0;
    consume      = 1'b0;
    old_BIP      = '0;
    new_BIP      = '0;
    ic_req_ready = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("reset_valids", 128'(vld), 128'(4'b0000));
    checkOutput("reset_req_valid", 128'(ic_req_valid), 128'(1'b0));

    // Sequential fill from the reset vector until full.
    exp_req_q.push_back(32'h100);
    exp_req_q.push_back(32'h110);
    exp_req_q.push_back(32'h120);
    exp_req_q.push_back(32'h130);
    reset = 1'b0;
    waitVld(4'b1111, 60, "fill_full");
    checkOutput("fill_line_00", line_00, pattern(32'h100));
    checkOutput("fill_line_01", line_01, pattern(32'h110));
    checkOutput("fill_line_10", line_10, pattern(32'h120));
    checkOutput("fill_line_11", line_11, pattern(32'h130));
    repeat (10) @(negedge clk);
    checkOutput("full_no_req", 128'(ic_req_valid), 128'(1'b0));
    checkOutput("full_queue_empty", 128'(exp_req_q.size()), 128'(0));

    // BIP crosses 00->01: slot 00 freed, refilled with 0x140.
    exp_req_q.push_back(32'h140);
    applyStimulus(1'b1, 6'h0E, 6'h12, 1'b0, 32'h0, 1'b1);
    checkOutput("free_00", 128'(vld), 128'(4'b1110));
    waitVld(4'b1111, 30, "refill_00");
    checkOutput("refill_line_00", line_00, pattern(32'h140));
    checkOutput("refill_line_01_kept", line_01, pattern(32'h110));

    // Wrap 11->00 frees slot 11; a move inside one line frees nothing.
    applyStimulus(1'b1, 6'h3C, 6'h02, 1'b0, 32'h0, 1'b1);
    checkOutput("wrap_free_11", 128'(vld), 128'(4'b0111));
    applyStimulus(1'b1, 6'h0C, 6'h0F, 1'b0, 32'h0, 1'b1);
    checkOutput("no_cross_keep", 128'(vld), 128'(4'b0111));
    repeat (5) @(negedge clk);
    checkOutput("fetch_slot_valid_idle", 128'(ic_req_valid), 128'(1'b0));

    // Flush while WAIT: response for 0x150 is dropped, refill from 0x2000.
    exp_req_q.push_back(32'h150);
    exp_req_q.push_back(32'h2000);
    exp_req_q.push_back(32'h2010);
    exp_req_q.push_back(32'h2020);
    exp_req_q.push_back(32'h2030);
    applyStimulus(1'b1, 6'h1E, 6'h22, 1'b0, 32'h0, 1'b1);
    checkOutput("free_01", 128'(vld), 128'(4'b0101));
    waitReq(20, "wait_req_150");
    @(negedge clk);
    applyStimulus(1'b0, 6'h0, 6'h0, 1'b1, 32'h2007, 1'b1);
    checkOutput("flush_wait_valids", 128'(vld), 128'(4'b0000));
    checkOutput("flush_wait_req", 128'(ic_req_valid), 128'(1'b0));
    @(negedge clk);
    checkOutput("drop_line_00_kept", line_00, pattern(32'h140));
    checkOutput("drop_line_01_kept", line_01, pattern(32'h110));
    checkOutput("drop_valids", 128'(vld), 128'(4'b0000));
    waitVld(4'b1111, 60, "flush_refill");
    checkOutput("flush_line_00", line_00, pattern(32'h2000));
    checkOutput("flush_line_11", line_11, pattern(32'h2030));

    // Flush in the same cycle the request is accepted: 0x2040 is dropped.
    applyStimulus(1'b1, 6'h0E, 6'h12, 1'b0, 32'h0, 1'b0);
    checkOutput("t5_free_00", 128'(vld), 128'(4'b1110));
    waitReq(20, "t5_req_seen");
    repeat (2) @(negedge clk);
    checkOutput("req_held_valid", 128'(ic_req_valid), 128'(1'b1));
    checkOutput("req_held_addr", 128'(ic_req_addr), 128'(32'h2040));
    exp_req_q.push_back(32'h2040);
    exp_req_q.push_back(32'h3000);
    exp_req_q.push_back(32'h3010);
    exp_req_q.push_back(32'h3020);
    exp_req_q.push_back(32'h3030);
    applyStimulus(1'b0, 6'h0, 6'h0, 1'b1, 32'h3005, 1'b1);
    checkOutput("flush_ready_valids", 128'(vld), 128'(4'b0000));
    checkOutput("flush_ready_req", 128'(ic_req_valid), 128'(1'b0));
    waitVld(4'b1111, 60, "t5_refill");
    checkOutput("t5_line_00", line_00, pattern(32'h3000));
    checkOutput("t5_line_10", line_10, pattern(32'h3020));

    // Reset while WAIT: no stale fill, restart from the reset vector.
    exp_req_q.push_back(32'h3040);
    applyStimulus(1'b1, 6'h0E, 6'h12, 1'b0, 32'h0, 1'b1);
    waitReq(20, "t6_req_seen");
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("midreset_valids", 128'(vld), 128'(4'b0000));
    checkOutput("midreset_req", 128'(ic_req_valid), 128'(1'b0));
    exp_req_q.push_back(32'h100);
    exp_req_q.push_back(32'h110);
    exp_req_q.push_back(32'h120);
    exp_req_q.push_back(32'h130);
    reset = 1'b0;
    waitVld(4'b1111, 60, "t6_refill");
    checkOutput("t6_line_00", line_00, pattern(32'h100));
    checkOutput("t6_line_11", line_11, pattern(32'h130));
    repeat (5) @(negedge clk);
    checkOutput("final_queue_empty", 128'(exp_req_q.size()), 128'(0));

    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

endmodule
